cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 150 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Collects results from NUM_SRC functional units and broadcasts one per
//   cycle on the common data bus. Each source owns a 2-entry FIFO of
//   {tag, data}. A round-robin arbiter picks a non-empty FIFO each cycle,
//   pops its head and registers it onto the CDB outputs.
//
// Ports
//   clk        : clock, rising edge
//   resetn     : synchronous active-low reset (wins over flush)
//   flush      : discard all buffered results and restart arbitration at 0
//   fu_valid   : per-source result valid
//   fu_tag     : per-source tag, source i at [i*TAG_WIDTH +: TAG_WIDTH]
//   fu_data    : per-source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fu_ready   : per-source FIFO not full (registered state only)
//   cdb_valid  : broadcast valid (registered)
//   cdb_tag    : broadcast tag (registered)
//   cdb_data   : broadcast data (registered)
//   cdb_src    : index of the granted source (registered)
module cdb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int NUM_SRC    = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           flush,
  input  logic [NUM_SRC-1:0]             fu_valid,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]   fu_tag,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  fu_data,
  output logic [NUM_SRC-1:0]             fu_ready,
  output logic                           cdb_valid,
  output logic [TAG_WIDTH-1:0]           cdb_tag,
  output logic [DATA_WIDTH-1:0]          cdb_data,
  output logic [$clog2(NUM_SRC)-1:0]     cdb_src
);

  localparam int          SRC_W  = $clog2(NUM_SRC);
  localparam int          ENT_W  = TAG_WIDTH + DATA_WIDTH;
  localparam int unsigned NSRC_U = NUM_SRC;
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

  // Per-source FIFO: r_ent0 is always the head, r_ent1 the second entry.
  logic [ENT_W-1:0]      r_ent0 [NUM_SRC];
  logic [ENT_W-1:0]      r_ent1 [NUM_SRC];
  logic [1:0]            r_occ  [NUM_SRC];
  logic [SRC_W-1:0]      r_rr_ptr;

  logic                  r_cdb_valid;
  logic [TAG_WIDTH-1:0]  r_cdb_tag;
  logic [DATA_WIDTH-1:0] r_cdb_data;
  logic [SRC_W-1:0]      r_cdb_src;

  logic                  w_grant;
  logic [SRC_W-1:0]      w_winner;
  logic [SRC_W-1:0]      w_rr_next;
  logic [NUM_SRC-1:0]    w_push;
  logic [NUM_SRC-1:0]    w_pop;
  logic [ENT_W-1:0]      w_in [NUM_SRC];

  // Ready depends only on occupancy, so a full FIFO refuses a push even
  // when it is being popped in the same cycle.
  always_comb begin
    fu_ready = '0;
    w_push   = '0;
    for (int unsigned i = 0; i < NSRC_U; i++) begin
      fu_ready[i] = ~r_occ[i][1];
      w_push[i]   = fu_valid[i] & ~r_occ[i][1];
      w_in[i]     = {fu_tag[i*TAG_WIDTH +: TAG_WIDTH],
                     fu_data[i*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  // Round-robin search from r_rr_ptr upward, wrapping at NUM_SRC-1.
  // Only entries already stored are eligible, so there is no bypass path.
  always_comb begin : arb
    int unsigned idx;
    w_grant  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NSRC_U; k++) begin
      idx = (32'(r_rr_ptr) + k) % NSRC_U;
      if (!w_grant && (r_occ[SRC_W'(idx)] != 2'd0)) begin
        w_grant  = 1'b1;
        w_winner = SRC_W'(idx);
      end
    end
    w_rr_next = (w_winner == LAST_SRC) ? '0 : w_winner + 1'b1;
    w_pop = '0;
    for (int unsigned i = 0; i < NSRC_U; i++) begin
      w_pop[i] = w_grant && (w_winner == SRC_W'(i));
    end
  end

  // Control state: occupancies, arbitration pointer and CDB registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NSRC_U; i++) begin
        r_occ[i] <= '0;
      end
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NSRC_U; i++) begin
        r_occ[i] <= '0;
      end
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NSRC_U; i++) begin
        r_occ[i] <= r_occ[i] + {1'b0, w_push[i]} - {1'b0, w_pop[i]};
      end
      if (w_grant) begin
        r_cdb_valid              <= 1'b1;
        {r_cdb_tag, r_cdb_data}  <= r_ent0[w_winner];
        r_cdb_src                <= w_winner;
        r_rr_ptr                 <= w_rr_next;
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  // FIFO storage needs no reset; occupancy alone says what is valid.
  // A push lands in the head slot when the FIFO is empty or when the
  // single stored entry leaves this cycle; otherwise it goes behind it.
  always_ff @(posedge clk) begin
    if (resetn && !flush) begin
      for (int unsigned i = 0; i < NSRC_U; i++) begin
        if (w_push[i]) begin
          if ((r_occ[i] == 2'd0) || w_pop[i]) begin
            r_ent0[i] <= w_in[i];
          end else begin
            r_ent1[i] <= w_in[i];
          end
        end else if (w_pop[i]) begin
          r_ent0[i] <= r_ent1[i];
        end
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;
  assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: queue-based reference model plus a negedge
// monitor that pops expected broadcasts from a scoreboard queue.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              flush = 1'b0;
  logic [N-1:0]      fu_valid = '0;
  logic [N*TW-1:0]   fu_tag = '0;
  logic [N*DW-1:0]   fu_data = '0;
  logic [N-1:0]      fu_ready;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic [SW-1:0]     cdb_src;

  cdb_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_SRC(N)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [TW-1:0] tag; logic [DW-1:0] data; } ent_t;
  typedef struct packed { logic [SW-1:0] src; logic [TW-1:0] tag; logic [DW-1:0] data; } bc_t;

  ent_t        mq [N][$];
  bc_t         exp_q [$];
  int          bc_log [$];
  int unsigned tq1 [$];
  int          total = 0;
  int          bad = 0;

  logic [N-1:0]  m_acc = '0;
  logic [N-1:0]  m_ready = '1;
  int            m_rr = 0;
  logic [TW-1:0] m_tag = '0;
  logic [DW-1:0] m_data = '0;
  logic [SW-1:0] m_src = '0;
  bit            mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-source queues of at most 2 results; each edge the
  // first non-empty queue at or after the pointer (cyclically) is served
  // from what was stored before the edge, then new offers are appended.
  always @(posedge clk) begin : model
    int   win;
    ent_t e;
    bc_t  b;
    if (!resetn) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exp_q.delete();
      m_rr = 0; m_tag = '0; m_data = '0; m_src = '0; m_acc = '0;
      mon_en = 1'b1;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exp_q.delete();
      m_rr = 0; m_acc = '0;
    end else begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && mq[(m_rr + k) % N].size() > 0) win = (m_rr + k) % N;
      end
      for (int i = 0; i < N; i++) m_acc[i] = fu_valid[i] && (mq[i].size() < 2);
      if (win >= 0) begin
        e = mq[win].pop_front();
        m_tag = e.tag; m_data = e.data; m_src = SW'(win);
        m_rr = (win + 1) % N;
        b.src = SW'(win); b.tag = e.tag; b.data = e.data;
        exp_q.push_back(b);
      end
      for (int i = 0; i < N; i++) begin
        if (m_acc[i]) begin
          e.tag  = fu_tag[i*TW +: TW];
          e.data = fu_data[i*DW +: DW];
          mq[i].push_back(e);
        end
      end
    end
    for (int i = 0; i < N; i++) m_ready[i] = (mq[i].size() < 2);
  end

  // Monitor: compare whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin : monitor
    bc_t b;
    if (mon_en) begin
      chk("fu_ready", 64'(fu_ready), 64'(m_ready));
      if (cdb_valid === 1'b1) begin
        bc_log.push_back(int'(cdb_src) * 16 + int'(cdb_tag));
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bcast: got src=%0d tag=%0h, expected no broadcast (t=%0t)",
                   cdb_src, cdb_tag, $time);
        end else begin
          b = exp_q.pop_front();
          chk("bcast_src", 64'(cdb_src), 64'(b.src));
          chk("bcast_tag", 64'(cdb_tag), 64'(b.tag));
          chk("bcast_data", 64'(cdb_data), 64'(b.data));
        end
      end else begin
        chk("cdb_valid", 64'(cdb_valid), 64'(exp_q.size() != 0));
        exp_q.delete();
        chk("hold_tag", 64'(cdb_tag), 64'(m_tag));
        chk("hold_data", 64'(cdb_data), 64'(m_data));
        chk("hold_src", 64'(cdb_src), 64'(m_src));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fu_valid = '0;
    repeat (n) cyc();
  endtask

  // Sources hold an offer until the model accepts it, then may offer anew.
  task automatic drive_step(input logic [N-1:0] want);
    for (int i = 0; i < N; i++) begin
      if (fu_valid[i] && m_acc[i]) fu_valid[i] = 1'b0;
      if (!fu_valid[i] && want[i]) begin
        fu_valid[i] = 1'b1;
        if (i == 1 && tq1.size() > 0) fu_tag[i*TW +: TW] = TW'(tq1.pop_front());
        else                          fu_tag[i*TW +: TW] = TW'($urandom_range(0, 15));
        fu_data[i*DW +: DW] = $urandom;
      end
    end
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s;
    int prev;
    int alt_bad;
    int src1_tags [$];

    // reset
    resetn = 1'b0;
    repeat (2) cyc();
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_tag", 64'(cdb_tag), 64'd0);
    chk("rst_data", 64'(cdb_data), 64'd0);
    chk("rst_src", 64'(cdb_src), 64'd0);
    chk("rst_ready", 64'(fu_ready), 64'hF);
    cyc();

    // single result with two-edge latency
    fu_valid[2] = 1'b1;
    fu_tag[2*TW +: TW] = 4'd5;
    fu_data[2*DW +: DW] = 32'hDEADBEEF;
    cyc();
    fu_valid = '0;
    @(negedge clk);
    chk("single_early", 64'(cdb_valid), 64'd0);
    @(negedge clk);
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_tag", 64'(cdb_tag), 64'd5);
    chk("single_data", 64'(cdb_data), 64'hDEADBEEF);
    chk("single_src", 64'(cdb_src), 64'd2);
    @(negedge clk);
    chk("single_after", 64'(cdb_valid), 64'd0);
    cyc();

    // contention: all four at once, pointer at 0
    flush = 1'b1; cyc(); flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      fu_valid[i] = 1'b1;
      fu_tag[i*TW +: TW] = TW'(i + 1);
      fu_data[i*DW +: DW] = $urandom;
    end
    cyc();
    fu_valid = '0;
    bc_log.delete();
    idle(5);
    chk("cont_count", 64'(bc_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < bc_log.size(); k++)
      chk("cont_order", 64'(bc_log[k]), 64'(k * 16 + k + 1));

    // fairness: src0 and src3 continuously valid
    bc_log.delete();
    repeat (16) drive_step(4'b1001);
    idle(6);
    chk("fair_count", 64'(bc_log.size() >= 12), 64'd1);
    alt_bad = 0;
    prev = -1;
    for (int k = 0; k < 12 && k < bc_log.size(); k++) begin
      s = bc_log[k] / 16;
      if (s != 0 && s != 3) alt_bad++;
      if (s == prev) alt_bad++;
      prev = s;
    end
    chk("fair_alternate", 64'(alt_bad), 64'd0);
    if (bc_log.size() > 0) chk("fair_first", 64'(bc_log[0] / 16), 64'd0);

    // full / order on src1
    flush = 1'b1; cyc(); flush = 1'b0;
    bc_log.delete();
    tq1.delete();
    tq1.push_back(7); tq1.push_back(8); tq1.push_back(9);
    drive_step(4'b0011);
    drive_step(4'b0011);
    @(negedge clk);
    chk("full_ready1", 64'(fu_ready[1]), 64'd0);
    repeat (8) drive_step({2'b00, tq1.size() > 0, 1'b1});
    idle(6);
    src1_tags.delete();
    foreach (bc_log[k]) if (bc_log[k] / 16 == 1) src1_tags.push_back(bc_log[k] % 16);
    chk("order_count", 64'(src1_tags.size()), 64'd3);
    for (int k = 0; k < 3 && k < src1_tags.size(); k++)
      chk("order_tag", 64'(src1_tags[k]), 64'(7 + k));

    // flush with three buffered results and a simultaneous offer
    for (int i = 0; i < 3; i++) begin
      fu_valid[i] = 1'b1;
      fu_tag[i*TW +: TW] = TW'(i + 1);
      fu_data[i*DW +: DW] = $urandom;
    end
    cyc();
    flush = 1'b1;
    fu_valid = 4'b1000;
    fu_tag[3*TW +: TW] = 4'hC;
    cyc();
    flush = 1'b0;
    fu_valid = '0;
    @(negedge clk);
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    chk("flush_ready", 64'(fu_ready), 64'hF);
    n = bc_log.size();
    idle(6);
    chk("flush_quiet", 64'(bc_log.size()), 64'(n));

    // reset mid-stream with two results pending
    fu_valid = 4'b0011;
    fu_tag[0 +: TW] = 4'hA;
    fu_tag[TW +: TW] = 4'hB;
    cyc();
    resetn = 1'b0;
    fu_valid = '0;
    cyc();
    resetn = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 64'(cdb_valid), 64'd0);
    chk("mrst_tag", 64'(cdb_tag), 64'd0);
    chk("mrst_data", 64'(cdb_data), 64'd0);
    chk("mrst_src", 64'(cdb_src), 64'd0);
    chk("mrst_ready", 64'(fu_ready), 64'hF);
    n = bc_log.size();
    idle(6);
    chk("mrst_quiet", 64'(bc_log.size()), 64'(n));

    // randomized traffic with occasional flush and reset
    repeat (3000) begin
      flush  = ($urandom_range(0, 63) == 0);
      resetn = ($urandom_range(0, 399) != 0);
      drive_step(N'($urandom));
    end
    resetn = 1'b1;
    flush  = 1'b0;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
